// File: rtl/noc_translator_pkg.sv
// Shared flit-format helpers for the 3-flit NoC translators (packetizer and depacketizer).
// Flit layout, MSB first: {valid, head, tail, vc, [dst], payload, zero pad}.
package noc_translator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_HOLD = 2'd2
  } depkt_state_e;

  function automatic int valid_bit(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int head_bit(input int flit_w);
    return flit_w - 2;
  endfunction

  function automatic int tail_bit(input int flit_w);
    return flit_w - 3;
  endfunction

  function automatic int vc_msb(input int flit_w);
    return flit_w - 4;
  endfunction

  function automatic int dst_msb(input int flit_w, input int vc_w);
    return flit_w - 4 - vc_w;
  endfunction

  function automatic int head_payload_w(input int flit_w, input int addr_w, input int vc_w);
    return flit_w - 3 - addr_w - vc_w;
  endfunction

  function automatic int body_payload_w(input int flit_w, input int vc_w);
    return flit_w - 3 - vc_w;
  endfunction

  function automatic int num_flits(input int width_in, input int h, input int b);
    if (width_in <= h) return 1;
    else if (width_in <= h + b) return 2;
    else return 3;
  endfunction

endpackage

// File: rtl/depacketizer_3_flit_field_extract.sv
// Combinational split of one flit into its control fields and head/body payload views.
module flit_field_extract
  import noc_translator_pkg::*;
#(
  parameter int FLIT_WIDTH       = 12,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  localparam int H = head_payload_w(FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH),
  localparam int B = body_payload_w(FLIT_WIDTH, VC_ADDRESS_WIDTH)
) (
  input  logic [FLIT_WIDTH-1:0]       flit,
  output logic                        valid,
  output logic                        head,
  output logic                        tail,
  output logic [VC_ADDRESS_WIDTH-1:0] vc,
  output logic [ADDRESS_WIDTH-1:0]    dst,
  output logic [H-1:0]                head_payload,
  output logic [B-1:0]                body_payload
);

  assign valid        = flit[valid_bit(FLIT_WIDTH)];
  assign head         = flit[head_bit(FLIT_WIDTH)];
  assign tail         = flit[tail_bit(FLIT_WIDTH)];
  assign vc           = flit[vc_msb(FLIT_WIDTH) -: VC_ADDRESS_WIDTH];
  assign dst          = flit[dst_msb(FLIT_WIDTH, VC_ADDRESS_WIDTH) -: ADDRESS_WIDTH];
  // The payload field runs down to bit 0; unused low bits are the zero pad.
  assign head_payload = flit[H-1:0];
  assign body_payload = flit[B-1:0];

endmodule

// File: rtl/depacketizer_3.sv
// Reassembles 3-flit-format packets into one WIDTH_IN word with framing-error detection.
// Optional DEPACKETIZER_ERR_CNT_EN adds a saturating 16-bit framing-error counter port.
module depacketizer_3
  import noc_translator_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 12,
  parameter int WIDTH_OUT        = 36
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_OUT/3-1:0]      flit_in,
  output logic                        ready_out,
  output logic [WIDTH_IN-1:0]         data_out,
  output logic [ADDRESS_WIDTH-1:0]    dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        error_out
`ifdef DEPACKETIZER_ERR_CNT_EN
  , output logic [15:0]               err_count_out
`endif
);

  localparam int FLIT_WIDTH = WIDTH_OUT / 3;
  localparam int H          = head_payload_w(FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int B          = body_payload_w(FLIT_WIDTH, VC_ADDRESS_WIDTH);
  localparam int NUM_FLITS  = num_flits(WIDTH_IN, H, B);
  localparam int ASM_W      = H + 2 * B;
  localparam logic [1:0] LAST_K = 2'(NUM_FLITS);

  if (WIDTH_IN > H + 2 * B) begin : g_width_check
    $error("depacketizer_3: WIDTH_IN exceeds the payload capacity of three flits");
  end

  logic                        f_valid;
  logic                        f_head;
  logic                        f_tail;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;
  logic [ADDRESS_WIDTH-1:0]    f_dst;
  logic [H-1:0]                f_hpl;
  logic [B-1:0]                f_bpl;

  flit_field_extract #(
    .FLIT_WIDTH      (FLIT_WIDTH),
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH)
  ) u_extract (
    .flit        (flit_in),
    .valid       (f_valid),
    .head        (f_head),
    .tail        (f_tail),
    .vc          (f_vc),
    .dst         (f_dst),
    .head_payload(f_hpl),
    .body_payload(f_bpl)
  );

  depkt_state_e        state, state_nxt;
  logic [1:0]          k, k_nxt;
  logic                accept, load_head, load_body, err_nxt;
  logic [WIDTH_IN-1:0] asm_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k     <= 2'd2;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // A draining HOLD behaves like IDLE for the flit accepted alongside it.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    load_head = 1'b0;
    load_body = 1'b0;
    err_nxt   = 1'b0;
    ready_out = (state != ST_HOLD) | ready_in;
    valid_out = (state == ST_HOLD);
    accept    = f_valid & ready_out;
    if (state == ST_HOLD && ready_in) state_nxt = ST_IDLE;
    if (accept) begin
      if (f_head) begin
        load_head = 1'b1;
        k_nxt     = 2'd2;
        if (state == ST_BODY) err_nxt = 1'b1;
        if (NUM_FLITS == 1) begin
          if (f_tail) state_nxt = ST_HOLD;
          else begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (f_tail) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_BODY;
        end
      end else if (state == ST_BODY) begin
        load_body = 1'b1;
        if (f_tail && k == LAST_K) state_nxt = ST_HOLD;
        else if (f_tail || k == LAST_K) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          k_nxt = k + 2'd1;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // Slices are placed in a virtual H+2B concatenation and the top WIDTH_IN bits kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_word  <= '0;
      dst_out   <= '0;
      vc_out    <= '0;
      error_out <= 1'b0;
    end else begin
      error_out <= err_nxt;
      if (load_head) begin
        asm_word <= WIDTH_IN'({f_hpl, {(2*B){1'b0}}} >> (ASM_W - WIDTH_IN));
        dst_out  <= f_dst;
        vc_out   <= f_vc;
      end else if (load_body) begin
        if (k == 2'd2)
          asm_word <= asm_word | WIDTH_IN'(ASM_W'({f_bpl, {B{1'b0}}}) >> (ASM_W - WIDTH_IN));
        else
          asm_word <= asm_word | WIDTH_IN'(ASM_W'(f_bpl) >> (ASM_W - WIDTH_IN));
      end
    end
  end

  assign data_out = asm_word;

`ifdef DEPACKETIZER_ERR_CNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_cnt <= '0;
    else if (err_nxt && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end

  assign err_count_out = err_cnt;
`endif

endmodule

// File: tb/tb_depacketizer_3.sv
// Scoreboard bench for depacketizer_3 at default parameters (H=4, B=8, two flits per word).
module tb_depacketizer_3;

  typedef struct packed {
    logic [11:0] data;
    logic [3:0]  dst;
    logic        vc;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] flit_in = '0;
  logic        ready_in = 1'b1;
  logic        ready_out, valid_out, error_out;
  logic [11:0] data_out;
  logic [3:0]  dst_out;
  logic        vc_out;
`ifdef DEPACKETIZER_ERR_CNT_EN
  logic [15:0] err_count_out;
`endif

  word_t sbq[$];
  int    errq[$];
  int    checks = 0, errors = 0, cyc = 0, err_total = 0, rdy_mode = 0;
  bit    held = 1'b0;
  word_t held_w;

  always #5 clk = ~clk;

  depacketizer_3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flit_in  (flit_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .dst_out  (dst_out),
    .vc_out   (vc_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .error_out(error_out)
`ifdef DEPACKETIZER_ERR_CNT_EN
    , .err_count_out(err_count_out)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ready_in = 1'b1;
      1:       ready_in = ($urandom_range(0, 3) != 0);
      default: ready_in = 1'b0;
    endcase
  end

  function automatic logic [11:0] hflit(input bit tail, input bit vc, input logic [3:0] dst,
                                        input logic [3:0] pl);
    return {1'b1, 1'b1, tail, vc, dst, pl};
  endfunction

  function automatic logic [11:0] bflit(input bit tail, input bit vc, input logic [7:0] pl);
    return {1'b1, 1'b0, tail, vc, pl};
  endfunction

  // Monitor: word scoreboard, hold stability, ready rule and error-pulse timing.
  always @(negedge clk) begin
    word_t cur, exp_w;
    cur = {data_out, dst_out, vc_out};
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!valid_out || cur != held_w) begin
          errors++;
          $display("FAIL hold_stable got valid=%b word=%h want valid=1 word=%h", valid_out, cur, held_w);
        end
      end
      checks++;
      if (ready_out !== (!valid_out || ready_in)) begin
        errors++;
        $display("FAIL ready_out got %b want %b", ready_out, (!valid_out || ready_in));
      end
      if (valid_out && ready_in) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL word unexpected got data=%h dst=%h vc=%b want none", data_out, dst_out, vc_out);
        end else begin
          exp_w = sbq.pop_front();
          if (cur != exp_w) begin
            errors++;
            $display("FAIL word got data=%h dst=%h vc=%b want data=%h dst=%h vc=%b",
                     cur.data, cur.dst, cur.vc, exp_w.data, exp_w.dst, exp_w.vc);
          end
        end
        held = 1'b0;
      end else if (valid_out) begin
        held   = 1'b1;
        held_w = cur;
      end else begin
        held = 1'b0;
      end
      if (error_out) begin
        checks++;
        if (errq.size() != 0 && errq[0] == cyc) void'(errq.pop_front());
        else begin
          errors++;
          $display("FAIL err_pulse unexpected at cycle %0d want cycle %0d", cyc,
                   (errq.size() != 0) ? errq[0] : -1);
        end
      end else if (errq.size() != 0 && errq[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL err_pulse missing got 0 want 1 at cycle %0d", errq[0]);
        void'(errq.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic send_flit(input logic [11:0] f, input bit bad);
    int n = 0;
    flit_in = f;
    @(negedge clk);
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready_out=0 want 1 within 200 cycles");
    end
    if (bad) begin
      errq.push_back(cyc + 1);
      err_total++;
    end
    @(posedge clk);
    #1 flit_in = '0;
  endtask

  task automatic bubble(input bit en);
    if (en && $urandom_range(0, 3) == 0) begin
      flit_in = {1'b0, 11'($urandom)};
      @(posedge clk);
      #1 flit_in = '0;
    end
  endtask

  // Expected word: head payload then body payload, MSB first, top 12 bits kept.
  task automatic good_pkt(input bit bad_head, input bit vc, input logic [3:0] dst,
                          input logic [3:0] hp, input logic [7:0] bp, input bit bub);
    word_t w;
    send_flit(hflit(1'b0, vc, dst, hp), bad_head);
    bubble(bub);
    send_flit(bflit(1'b1, 1'($urandom_range(0, 1)), bp), 1'b0);
    w.data = (12'(hp) << 8) | 12'(bp);
    w.dst  = dst;
    w.vc   = vc;
    sbq.push_back(w);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_out", 32'(ready_out), 32'd1);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_error_out", 32'(error_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_dst_out", 32'(dst_out), 32'd0);
    check("rst_vc_out", 32'(vc_out), 32'd0);
    @(posedge clk);
    #1;

    // Basic packet C5A / ABC, valid the cycle after the tail.
    good_pkt(1'b0, 1'b0, 4'h5, 4'hA, 8'hBC, 1'b0);
    @(negedge clk);
    check("latency_valid", 32'(valid_out), 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-packet: partial head dropped, following body is stray.
    send_flit(hflit(1'b0, 1'b0, 4'h5, 4'hA), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    err_total = 0;
    send_flit(bflit(1'b1, 1'b0, 8'hBC), 1'b1);

    // Stray body in IDLE, then a correct packet.
    send_flit(bflit(1'b1, 1'b0, 8'hBC), 1'b1);
    good_pkt(1'b0, 1'b0, 4'h5, 4'hA, 8'hBC, 1'b0);

    // Head interrupting a packet restarts assembly.
    send_flit(hflit(1'b0, 1'b0, 4'h5, 4'hA), 1'b0);
    good_pkt(1'b1, 1'b0, 4'h3, 4'h1, 8'h22, 1'b0);
`ifdef DEPACKETIZER_ERR_CNT_EN
    @(negedge clk);
    check("err_count_three", 32'(err_count_out), 32'd3);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back with ready_in held low for a while.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        good_pkt(1'b0, 1'b0, 4'h5, 4'hA, 8'hBC, 1'b0);
        @(negedge clk);
        check("bp_ready_out", 32'(ready_out), 32'd0);
        check("bp_valid_out", 32'(valid_out), 32'd1);
        good_pkt(1'b0, 1'b0, 4'h3, 4'h1, 8'h22, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 0;
      end
    join

    // Randomized traffic with random back-pressure and framing faults.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0: send_flit(bflit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom)), 1'b1);
        1: begin
          send_flit(hflit(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom)), 1'b0);
          bubble(1'b1);
          good_pkt(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 8'($urandom), 1'b1);
        end
        2: begin
          send_flit(hflit(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom)), 1'b0);
          bubble(1'b1);
          send_flit(bflit(1'b0, 1'($urandom_range(0, 1)), 8'($urandom)), 1'b1);
        end
        default:
          good_pkt(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 8'($urandom), 1'b1);
      endcase
      bubble(1'b1);
    end

    rdy_mode = 0;
    begin
      int n = 0;
      while ((sbq.size() != 0 || errq.size() != 0) && n < 200) begin
        @(posedge clk);
        n++;
      end
    end
    @(negedge clk);
    check("drain_words_left", 32'(sbq.size()), 32'd0);
    check("drain_errs_left", 32'(errq.size()), 32'd0);

`ifdef DEPACKETIZER_ERR_CNT_EN
    check("err_count_total", 32'(err_count_out), 32'(err_total));
    @(posedge clk);
    #1;
    force dut.err_cnt = 16'hFFFF;
    @(posedge clk);
    #1 release dut.err_cnt;
    send_flit(bflit(1'b1, 1'b0, 8'h11), 1'b1);
    repeat (2) @(negedge clk);
    check("err_count_saturate", 32'(err_count_out), 32'h0000FFFF);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
